// File: rtl/lognorm16_if.sv
// lognorm16_if: handshake bundle for the lognorm16 left-shift normalizer.
// The producer/consumer side uses the master modport; the normalizer uses slave.
interface lognorm16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_shamt;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_zero
  );
endinterface

// File: rtl/lognorm16.sv
// lognorm16: sequential left-shift normalizer for the 16-bit CORDIC datapath.
// Removes redundant sign bits with a logarithmic 8/4/2/1 shift sequence and
// reports the total shift applied (0..15) plus a flag for a zero operand.
// Build option: define LOGNORM16_FAST_EN to run two shift stages per clock
// (IDLE -> S84 -> S21 -> DONE); results are bit-identical to the default build.
module lognorm16 #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_b,
  lognorm16_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [3:0]       cnt;
  } norm_t;

`ifdef LOGNORM16_FAST_EN
  typedef enum logic [1:0] {IDLE, S84, S21, DONE} state_t;
  localparam state_t FIRST = S84;
`else
  typedef enum logic [2:0] {IDLE, S8, S4, S2, S1, DONE} state_t;
  localparam state_t FIRST = S8;
`endif

  // One shift stage: if the top k+1 bits are all copies of the sign, shift
  // left by k (zero fill) and add k to the count; otherwise pass through.
  // k = 0 is an identity stage.
  function automatic norm_t norm_stage(input norm_t s, input logic [3:0] k);
    logic signed [WIDTH-1:0] w;
    logic signed [WIDTH-1:0] top;
    norm_t                   r;
    r   = s;
    w   = s.data;
    top = w >>> (4'd15 - k);
    if ((top == '0) || (top == '1)) begin
      r.data = s.data << k;
      r.cnt  = s.cnt + k;
    end
    return r;
  endfunction

  state_t                  state;
  logic signed [WIDTH-1:0] work;
  logic [3:0]              cnt;
  logic                    zero_flag;
  logic                    accept;
  logic [3:0]              k_a;
  logic [3:0]              k_b;
  norm_t                   cur;
  norm_t                   step_a;
  norm_t                   step_b;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid && bus.in_ready;

  // Select the shift distances for the current state and evaluate the stages.
  always_comb begin
    k_a = 4'd0;
    k_b = 4'd0;
    unique case (state)
`ifdef LOGNORM16_FAST_EN
      S84: begin k_a = 4'd8; k_b = 4'd4; end
      S21: begin k_a = 4'd2; k_b = 4'd1; end
`else
      S8:  k_a = 4'd8;
      S4:  k_a = 4'd4;
      S2:  k_a = 4'd2;
      S1:  k_a = 4'd1;
`endif
      default: begin k_a = 4'd0; k_b = 4'd0; end
    endcase
    cur.data = work;
    cur.cnt  = cnt;
    step_a   = norm_stage(cur, k_a);
    step_b   = norm_stage(step_a, k_b);
  end

  // Control FSM with the work register and the registered result outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= IDLE;
      work          <= '0;
      cnt           <= '0;
      zero_flag     <= 1'b0;
      bus.out_data  <= '0;
      bus.out_shamt <= '0;
      bus.out_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            work      <= bus.in_data;
            cnt       <= '0;
            zero_flag <= (bus.in_data == '0);
            state     <= FIRST;
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
`ifdef LOGNORM16_FAST_EN
        S84: begin
          work  <= step_b.data;
          cnt   <= step_b.cnt;
          state <= S21;
        end
        S21: begin
          bus.out_data  <= step_b.data;
          bus.out_shamt <= step_b.cnt;
          bus.out_zero  <= zero_flag;
          state         <= DONE;
        end
`else
        S8: begin
          work  <= step_b.data;
          cnt   <= step_b.cnt;
          state <= S4;
        end
        S4: begin
          work  <= step_b.data;
          cnt   <= step_b.cnt;
          state <= S2;
        end
        S2: begin
          work  <= step_b.data;
          cnt   <= step_b.cnt;
          state <= S1;
        end
        S1: begin
          bus.out_data  <= step_b.data;
          bus.out_shamt <= step_b.cnt;
          bus.out_zero  <= zero_flag;
          state         <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lognorm16.sv
// tb_lognorm16: self-checking bench for lognorm16 (default and LOGNORM16_FAST_EN
// builds). A scoreboard predicts each result from the input word by counting
// leading sign bits; directed cases compare against fixed expected values.
module tb_lognorm16;

`ifdef LOGNORM16_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  localparam int SPACING = LAT + 1;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;

  lognorm16_if bus ();

  lognorm16 dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_hs = 0;
  int          hs_cyc[$];
  logic [15:0] hs_dat[$];
  logic [3:0]  hs_sh[$];
  exp_t        exp_q[$];
  bit          rand_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: r = number of bits below the MSB that equal the MSB, capped at 15.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int   r;
    r = 0;
    for (int i = 14; i >= 0; i--) begin
      if (w[i] != w[15]) break;
      r++;
    end
    if (r > 15) r = 15;
    e.d = w << r;
    e.r = 4'(r);
    e.z = (w == 16'h0000);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: predict on accept, compare on output handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_b) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {16'h0, bus.out_data}, {16'h0, e.d});
          chk("out_shamt", {28'h0, bus.out_shamt}, {28'h0, e.r});
          chk("out_zero", {31'h0, bus.out_zero}, {31'h0, e.z});
        end
        n_hs++;
        hs_cyc.push_back(cyc + 1);
        hs_dat.push_back(bus.out_data);
        hs_sh.push_back(bus.out_shamt);
      end
    end
  end

  // Present a word and keep in_valid high until the accepting edge has passed.
  task automatic send(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget && n_hs < target; i++) @(posedge clk);
    #1;
    if (n_hs < target) chk("handshake_timeout", n_hs, target);
  endtask

  logic [15:0] basic_in [7] = '{16'h0001, 16'h00FF, 16'h4000, 16'hC000, 16'hFFF0, 16'h0000, 16'hFFFF};
  logic [15:0] basic_d  [7] = '{16'h4000, 16'h7F80, 16'h4000, 16'h8000, 16'h8000, 16'h0000, 16'h8000};
  logic [3:0]  basic_r  [7] = '{4'd14, 4'd7, 4'd0, 4'd1, 4'd11, 4'd15, 4'd15};
  logic        basic_z  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int h;
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_shamt", bus.out_shamt, 0);
    chk("rst_out_zero", bus.out_zero, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Basic values and extremes
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      h = n_hs;
      send(basic_in[i]);
      bus.in_valid = 1'b0;
      wait_hs(h + 1, 50);
      chk("basic_data", bus.out_data, basic_d[i]);
      chk("basic_shamt", bus.out_shamt, basic_r[i]);
      chk("basic_zero", bus.out_zero, basic_z[i]);
    end

    // Backpressure on 0x0100
    bus.out_ready = 1'b0;
    h = n_hs;
    send(16'h0100);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, 16'h4000);
      chk("bp_shamt", bus.out_shamt, 6);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    chk("bp_no_early_hs", n_hs, h);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_hs(h + 1, 10);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_single_hs", n_hs, h + 1);
    chk("bp_valid_after", bus.out_valid, 0);

    // Back-to-back with in_valid held
    h = n_hs;
    hs_cyc.delete();
    hs_dat.delete();
    hs_sh.delete();
    send(16'h0003);
    send(16'hFF00);
    send(16'h1234);
    bus.in_valid = 1'b0;
    wait_hs(h + 3, 50);
    if (hs_dat.size() >= 3) begin
      chk("b2b_d0", hs_dat[0], 16'h6000);
      chk("b2b_r0", hs_sh[0], 13);
      chk("b2b_d1", hs_dat[1], 16'h8000);
      chk("b2b_r1", hs_sh[1], 7);
      chk("b2b_d2", hs_dat[2], 16'h48D0);
      chk("b2b_r2", hs_sh[2], 2);
      chk("b2b_gap01", hs_cyc[1] - hs_cyc[0], SPACING);
      chk("b2b_gap12", hs_cyc[2] - hs_cyc[1], SPACING);
    end else begin
      chk("b2b_count", hs_dat.size(), 3);
    end

    // Reset asserted while the word is in the second shift state
    send(16'h1234);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b0;
    exp_q.delete();
    h = n_hs;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_shamt", bus.out_shamt, 0);
    chk("midrst_out_zero", bus.out_zero, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    reset_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale_hs", n_hs, h);
    chk("midrst_valid_low", bus.out_valid, 0);

    // Random words with occasional consumer stalls
    h = n_hs;
    rand_done = 1'b0;
    fork
      begin
        logic signed [15:0] sv;
        logic [15:0]        w;
        for (int i = 0; i < 10000; i++) begin
          sv = 16'($urandom);
          if ($urandom_range(0, 1) == 0) w = sv;
          else w = sv >>> $urandom_range(0, 15);
          send(w);
        end
        bus.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 7) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_hs(h + 10000, 100);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
